acq_ctl: RTL and testbench

Acquisition sequencer placed in front of the stream-to-memory capture buffer. It gates the sample stream into the buffer, clears the buffer write pointer at each start, and counts pre-trigger and post-trigger samples. It terminates the record with TLAST and reports the trigger position and completion to software. Software controls it through a system-bus register window.

---
 rtl/acq_ctl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_acq_ctl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_ctl.sv
// acq_ctl -- acquisition sequencer in front of the stream-to-memory capture
// buffer. Gates the sample stream into the buffer, clears the buffer write
// pointer at each start, counts pre- and post-trigger samples, marks the last
// sample of a record with TLAST, and reports the trigger position and
// completion to software through a small bus register window.
//
// Parameters:
//   DL  capture buffer length in samples (power of 2)
//   DW  sample width
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   sti_tdata/tvalid/tready   sample stream from the source
//   sto_tdata/tvalid/tlast/   sample stream to the capture buffer
//   sto_tready
//   ctl_rst                   one-cycle buffer write-pointer clear
//   trg_ext                   external trigger, level-sampled
//   bus_addr/wdata/wen/ren    register access; bus_addr[4:2] selects
//   bus_rdata/ack/err         registered read data, one-cycle ack, err = 0
//   irq                       completion interrupt, level
//
// Register map (byte offsets):
//   0x00 CTL      W: bit0 start, bit1 stop, bit2 sw trigger
//                 R: {28'0, done, post, wait, arm}
//   0x04 CFG_PRE  pre-trigger sample count, clamped to DL
//   0x08 CFG_POST post-trigger sample count
//   0x0C TRG_PTR  buffer address of the first post-trigger sample (RO)
//   0x10 CNT      transfers since start, saturating (RO)
//   0x14 IRQ      R: status, W: 1 to clear
module acq_ctl #(
  parameter int unsigned DL = 16384,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] sti_tdata,
  input  logic          sti_tvalid,
  output logic          sti_tready,
  output logic [DW-1:0] sto_tdata,
  output logic          sto_tvalid,
  output logic          sto_tlast,
  input  logic          sto_tready,
  output logic          ctl_rst,
  input  logic          trg_ext,
  input  logic [31:0]   bus_addr,
  input  logic [31:0]   bus_wdata,
  input  logic          bus_wen,
  input  logic          bus_ren,
  output logic [31:0]   bus_rdata,
  output logic          bus_ack,
  output logic          bus_err,
  output logic          irq
);

  localparam int unsigned AW = $clog2(DL);
  localparam logic [AW:0] PRE_MAX = (AW+1)'(DL);

  localparam logic [2:0] REG_CTL  = 3'd0;
  localparam logic [2:0] REG_PRE  = 3'd1;
  localparam logic [2:0] REG_POST = 3'd2;
  localparam logic [2:0] REG_TRG  = 3'd3;
  localparam logic [2:0] REG_CNT  = 3'd4;
  localparam logic [2:0] REG_IRQ  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ARM,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   cfg_pre_q, cfg_pre_d;
  logic [31:0]   cfg_post_q, cfg_post_d;
  logic [AW:0]   pre_w_q, pre_w_d;
  logic [31:0]   post_w_q, post_w_d;
  logic [AW:0]   pre_cnt_q, pre_cnt_d;
  logic [31:0]   post_cnt_q, post_cnt_d;
  logic [AW-1:0] wad_q, wad_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [AW-1:0] trg_ptr_q, trg_ptr_d;
  logic          irq_q, irq_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [2:0] reg_sel;
  logic       wr_ctl, wr_pre, wr_post, wr_irq;
  logic       cmd_start, cmd_stop, cmd_swtrg;
  logic       active, xfer, trigger, post_last, irq_set;
  logic       unused_addr_bits;

  assign reg_sel = bus_addr[4:2];
  assign unused_addr_bits = ^{bus_addr[31:5], bus_addr[1:0]};

  assign wr_ctl  = bus_wen & (reg_sel == REG_CTL);
  assign wr_pre  = bus_wen & (reg_sel == REG_PRE);
  assign wr_post = bus_wen & (reg_sel == REG_POST);
  assign wr_irq  = bus_wen & (reg_sel == REG_IRQ);

  assign cmd_start = wr_ctl & bus_wdata[0];
  assign cmd_stop  = wr_ctl & bus_wdata[1];
  // A software trigger riding on a start write would otherwise land on
  // the run being torn down; it is dropped.
  assign cmd_swtrg = wr_ctl & bus_wdata[2] & ~bus_wdata[0];

  // Stream gating: forward during acquisition, otherwise drain the source.
  assign active     = (state_q == S_ARM) | (state_q == S_WAIT) | (state_q == S_POST);
  assign sto_tdata  = sti_tdata;
  assign sto_tvalid = active & sti_tvalid;
  assign sti_tready = active ? sto_tready : 1'b1;
  assign xfer       = sto_tvalid & sto_tready;

  assign trigger   = trg_ext | cmd_swtrg;
  assign post_last = (post_cnt_q == post_w_q - 32'd1);
  assign sto_tlast = (state_q == S_POST) & sti_tvalid & post_last;

  assign ctl_rst   = (state_q == S_CLR);
  assign irq       = irq_q;
  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;
  assign bus_err   = 1'b0;

  // Configuration registers
  always_comb begin
    cfg_pre_d  = cfg_pre_q;
    cfg_post_d = cfg_post_q;
    if (wr_pre) begin
      cfg_pre_d = (bus_wdata > DL) ? PRE_MAX : bus_wdata[AW:0];
    end
    if (wr_post) begin
      cfg_post_d = bus_wdata;
    end
  end

  // Sequencer: next state, counters, trigger pointer, interrupt status
  always_comb begin
    state_d    = state_q;
    pre_w_d    = pre_w_q;
    post_w_d   = post_w_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    wad_d      = wad_q;
    cnt_d      = cnt_q;
    trg_ptr_d  = trg_ptr_q;
    irq_set    = 1'b0;
    irq_d      = irq_q;

    if (xfer) begin
      wad_d = wad_q + AW'(1);
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    unique case (state_q)
      S_IDLE: ;
      S_CLR: begin
        wad_d      = '0;
        cnt_d      = '0;
        pre_cnt_d  = '0;
        post_cnt_d = '0;
        pre_w_d    = cfg_pre_q;
        post_w_d   = cfg_post_q;
        state_d    = (cfg_pre_q == '0) ? S_WAIT : S_ARM;
      end
      S_ARM: begin
        if (xfer) begin
          pre_cnt_d = pre_cnt_q + (AW+1)'(1);
          if (pre_cnt_q + (AW+1)'(1) == pre_w_q) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (trigger) begin
          // A transfer in the trigger cycle is still pre-trigger, so the
          // first post-trigger sample sits one address further on.
          trg_ptr_d = wad_q + AW'(xfer);
          state_d   = (post_w_q == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (xfer) begin
          post_cnt_d = post_cnt_q + 32'd1;
          if (post_last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // Stop overrides start; either one abandons a trigger seen this cycle.
    if (cmd_stop) begin
      state_d   = S_IDLE;
      trg_ptr_d = trg_ptr_q;
    end else if (cmd_start) begin
      state_d   = S_CLR;
      trg_ptr_d = trg_ptr_q;
    end

    irq_set = (state_d == S_DONE) & (state_q != S_DONE);
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (wr_irq & bus_wdata[0]) begin
      irq_d = 1'b0;
    end
  end

  // Bus read path, registered so data lines up with ack
  always_comb begin
    ack_d   = bus_wen | bus_ren;
    rdata_d = '0;
    if (bus_ren) begin
      unique case (reg_sel)
        REG_CTL:  rdata_d = {28'd0, state_q == S_DONE, state_q == S_POST,
                             state_q == S_WAIT, state_q == S_ARM};
        REG_PRE:  rdata_d = {{(31-AW){1'b0}}, cfg_pre_q};
        REG_POST: rdata_d = cfg_post_q;
        REG_TRG:  rdata_d = {{(32-AW){1'b0}}, trg_ptr_q};
        REG_CNT:  rdata_d = cnt_q;
        REG_IRQ:  rdata_d = {31'd0, irq_q};
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cfg_pre_q  <= '0;
      cfg_post_q <= '0;
      pre_w_q    <= '0;
      post_w_q   <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      wad_q      <= '0;
      cnt_q      <= '0;
      trg_ptr_q  <= '0;
      irq_q      <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cfg_pre_q  <= cfg_pre_d;
      cfg_post_q <= cfg_post_d;
      pre_w_q    <= pre_w_d;
      post_w_q   <= post_w_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      wad_q      <= wad_d;
      cnt_q      <= cnt_d;
      trg_ptr_q  <= trg_ptr_d;
      irq_q      <= irq_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_acq_ctl.sv
// Bench for acq_ctl with a 16-sample buffer. Full acquisition runs are
// described by a table of configurations and hand-computed results; the
// stop, restart and interrupt corner cases are written out by hand.
module tb_acq_ctl;

  localparam int unsigned DL = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] sti_tdata;
  logic          sti_tvalid = 1'b0;
  logic          sti_tready;
  logic [DW-1:0] sto_tdata;
  logic          sto_tvalid;
  logic          sto_tlast;
  logic          sto_tready;
  logic          ctl_rst;
  logic          trg_ext = 1'b0;
  logic [31:0]   bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic          bus_wen = 1'b0;
  logic          bus_ren = 1'b0;
  logic [31:0]   bus_rdata;
  logic          bus_ack;
  logic          bus_err;
  logic          irq;

  acq_ctl #(.DL(DL), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .sti_tdata(sti_tdata), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
    .sto_tdata(sto_tdata), .sto_tvalid(sto_tvalid), .sto_tlast(sto_tlast),
    .sto_tready(sto_tready), .ctl_rst(ctl_rst), .trg_ext(trg_ext),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen),
    .bus_ren(bus_ren), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err), .irq(irq)
  );

  always #5 clk = ~clk;

  // Source: numbered samples, advancing on each source handshake.
  // Sink: ready either always or alternating every cycle.
  logic [15:0] src_ctr = '0;
  logic        phase = 1'b0;
  logic        tog_en = 1'b0;
  always @(posedge clk) begin
    phase <= ~phase;
    if (sti_tvalid && sti_tready) src_ctr <= src_ctr + 16'd1;
  end
  assign sti_tdata  = src_ctr;
  assign sto_tready = tog_en ? phase : 1'b1;

  // Buffer-side log: address = transfers since the last pointer clear.
  int          mon_addr = 0;
  int          log_n = 0;
  int          rst_cnt = 0;
  logic [3:0]  addr_log [64];
  logic        last_log [64];
  logic [15:0] data_log [64];
  always @(negedge clk) begin
    if (ctl_rst) begin
      rst_cnt = rst_cnt + 1;
      mon_addr = 0;
      log_n = 0;
    end
    if (sto_tvalid && sto_tready) begin
      if (log_n < 64) begin
        addr_log[log_n] = 4'(mon_addr);
        last_log[log_n] = sto_tlast;
        data_log[log_n] = sto_tdata;
      end
      log_n = log_n + 1;
      mon_addr = (mon_addr + 1) % 16;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    cyc();
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    cyc();
    bus_wen = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    cyc();
    bus_addr = a; bus_ren = 1'b1;
    cyc();
    bus_ren = 1'b0;
    check({name, "_ack"}, bus_ack, 1'b1);
    check(name, bus_rdata, exp);
  endtask

  // Advance until the current cycle carries the transfer of buffer address a.
  task automatic wait_addr(input string name, input int a);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sto_tvalid && sto_tready && mon_addr == a) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check(name, found, 1'b1);
  endtask

  task automatic wait_irq(input string name);
    for (int k = 0; k < 200; k++) begin
      if (irq) break;
      cyc();
    end
    check(name, irq, 1'b1);
  endtask

  typedef struct {
    int pre;
    int post;
    int held;       // 1: trg_ext held high from before start
    int trig_addr;  // otherwise: pulse during the transfer of this address
    int tog;        // alternate sink ready
    int exp_ptr;
    int exp_last;
    int exp_cnt;
  } scen_t;

  scen_t tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r0, nlast, nbreak, idx;

    tbl[0] = '{4, 6, 0,  9, 0, 10, 15, 16};
    tbl[1] = '{4, 8, 0, 13, 0, 14,  5, 22};
    tbl[2] = '{2, 3, 0,  3, 1,  4,  6,  7};
    tbl[3] = '{4, 2, 1,  0, 0,  5,  6,  7};

    sti_tvalid = 1'b1;
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();

    // Reset state
    check("rst_ctl_rst", ctl_rst, 1'b0);
    check("rst_sto_tvalid", sto_tvalid, 1'b0);
    check("rst_sto_tlast", sto_tlast, 1'b0);
    check("rst_sti_tready", sti_tready, 1'b1);
    check("rst_bus_ack", bus_ack, 1'b0);
    check("rst_bus_rdata", bus_rdata, 32'd0);
    check("rst_irq", irq, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    bus_read("rst_ctl", 32'h00, 32'd0);
    bus_read("rst_pre", 32'h04, 32'd0);
    bus_read("rst_post", 32'h08, 32'd0);
    bus_read("rst_trg_ptr", 32'h0C, 32'd0);
    bus_read("rst_cnt", 32'h10, 32'd0);
    bus_read("rst_irq_reg", 32'h14, 32'd0);

    // CFG_PRE clamping and unmapped reads
    bus_write(32'h04, 32'd100);
    bus_read("pre_clamp_100", 32'h04, 32'd16);
    bus_write(32'h04, 32'd17);
    bus_read("pre_clamp_17", 32'h04, 32'd16);
    bus_write(32'h04, 32'd16);
    bus_read("pre_16", 32'h04, 32'd16);
    bus_read("unmapped_18", 32'h18, 32'd0);
    bus_read("unmapped_1c", 32'h1C, 32'd0);

    // Full acquisition runs
    for (int i = 0; i < 4; i++) begin
      bus_write(32'h04, 32'(tbl[i].pre));
      bus_write(32'h08, 32'(tbl[i].post));
      bus_write(32'h14, 32'd1);
      check($sformatf("r%0d_irq_clear", i), irq, 1'b0);
      tog_en = (tbl[i].tog != 0);
      trg_ext = (tbl[i].held != 0);
      r0 = rst_cnt;
      bus_write(32'h00, 32'd1);
      check($sformatf("r%0d_ctl_rst_hi", i), ctl_rst, 1'b1);
      cyc();
      check($sformatf("r%0d_ctl_rst_lo", i), ctl_rst, 1'b0);
      if (tbl[i].held == 0) begin
        wait_addr($sformatf("r%0d_trig_xfer", i), tbl[i].trig_addr);
        trg_ext = 1'b1;
        cyc();
        trg_ext = 1'b0;
      end
      wait_irq($sformatf("r%0d_irq", i));
      trg_ext = 1'b0;
      check($sformatf("r%0d_rst_pulses", i), 32'(rst_cnt - r0), 32'd1);
      bus_read($sformatf("r%0d_trg_ptr", i), 32'h0C, 32'(tbl[i].exp_ptr));
      bus_read($sformatf("r%0d_cnt", i), 32'h10, 32'(tbl[i].exp_cnt));
      bus_read($sformatf("r%0d_ctl_done", i), 32'h00, 32'd8);
      check($sformatf("r%0d_log_n", i), 32'(log_n), 32'(tbl[i].exp_cnt));
      nlast = 0;
      nbreak = 0;
      for (int j = 0; j < log_n && j < 64; j++) begin
        if (last_log[j]) nlast++;
        if (j > 0 && data_log[j] != data_log[j-1] + 16'd1) nbreak++;
      end
      idx = (log_n >= 1 && log_n <= 64) ? log_n - 1 : 0;
      check($sformatf("r%0d_tlast_count", i), 32'(nlast), 32'd1);
      check($sformatf("r%0d_tlast_pos", i), 32'(last_log[idx]), 32'd1);
      check($sformatf("r%0d_last_addr", i), 32'(addr_log[idx]), 32'(tbl[i].exp_last));
      check($sformatf("r%0d_data_gaps", i), 32'(nbreak), 32'd0);
    end
    tog_en = 1'b0;
    bus_write(32'h14, 32'd1);

    // Stop in the middle of POST
    bus_write(32'h04, 32'd2);
    bus_write(32'h08, 32'd20);
    bus_write(32'h00, 32'd1);
    wait_addr("stop_trig_xfer", 3);
    trg_ext = 1'b1;
    cyc();
    trg_ext = 1'b0;
    bus_read("stop_ctl_post", 32'h00, 32'd4);
    wait_addr("stop_xfer8", 8);
    bus_write(32'h00, 32'd2);
    check("stop_tvalid", sto_tvalid, 1'b0);
    check("stop_tlast", sto_tlast, 1'b0);
    repeat (5) cyc();
    check("stop_irq", irq, 1'b0);
    bus_read("stop_ctl_idle", 32'h00, 32'd0);
    bus_read("stop_trg_ptr", 32'h0C, 32'd4);

    // Start and stop in one write
    r0 = rst_cnt;
    bus_write(32'h00, 32'd3);
    repeat (3) cyc();
    check("startstop_no_clr", 32'(rst_cnt - r0), 32'd0);
    bus_read("startstop_ctl", 32'h00, 32'd0);

    // Software trigger in the start write is dropped
    bus_write(32'h04, 32'd0);
    bus_write(32'h08, 32'd0);
    bus_write(32'h00, 32'd5);
    repeat (3) cyc();
    bus_read("start_swtrg_wait", 32'h00, 32'd2);
    check("start_swtrg_irq", irq, 1'b0);
    bus_write(32'h00, 32'd2);

    // PRE=0 POST=0: CLR -> WAIT -> DONE on the next software trigger
    bus_write(32'h00, 32'd1);
    check("z_ctl_rst", ctl_rst, 1'b1);
    bus_write(32'h00, 32'd4);
    check("z_irq", irq, 1'b1);
    bus_read("z_trg_ptr", 32'h0C, 32'd1);
    bus_read("z_cnt", 32'h10, 32'd1);
    bus_read("z_ctl_done", 32'h00, 32'd8);
    check("z_log_n", 32'(log_n), 32'd1);
    check("z_no_tlast", 32'(last_log[0]), 32'd0);
    bus_write(32'h14, 32'd1);
    check("z_irq_cleared", irq, 1'b0);
    bus_read("z_irq_reg", 32'h14, 32'd0);

    // Interrupt set and write-1 clear in the same cycle
    bus_write(32'h00, 32'd1);
    cyc();
    bus_addr = 32'h14; bus_wdata = 32'd1; bus_wen = 1'b1;
    trg_ext = 1'b1;
    cyc();
    bus_wen = 1'b0;
    trg_ext = 1'b0;
    check("setclr_irq", irq, 1'b1);
    bus_read("setclr_irq_reg", 32'h14, 32'd1);
    bus_write(32'h14, 32'd1);
    check("setclr_cleared", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
